// File: rtl/spi_pkg.sv
// spi_pkg: FSM state encoding and byte width shared by the SPI master files.
package spi_pkg;
    localparam int SPI_BYTE_W = 8;
    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} spi_state_t;
endpackage

// File: rtl/spi_clk_div.sv
// spi_clk_div: SCLK half-period tick; the count restarts from 0 whenever en is low.
module spi_clk_div #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic tick
);
    localparam int W = $clog2(CLK_DIV);
    localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);
    logic [W-1:0] cnt;
    assign tick = en && cnt == LAST;
    always_ff @(posedge clk or posedge reset)
        if (reset) cnt <= '0;
        else cnt <= (!en || tick) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/spi_master.sv
// spi_master: mode-0 SPI master, one byte per chip-select frame, MSB first.
// Define SPI_MASTER_LOOPBACK_EN to receive the internal MOSI instead of spi_miso.
module spi_master
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [SPI_BYTE_W-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [SPI_BYTE_W-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  busy,
    output logic                  spi_sclk,
    output logic                  spi_mosi,
    output logic                  spi_cs_n,
    input  logic                  spi_miso
);
    if (CLK_DIV < 2) begin : g_bad_div
        $error("spi_master: CLK_DIV must be >= 2");
    end
    spi_state_t            state;
    logic [SPI_BYTE_W-2:0] tx_sr;
    logic [SPI_BYTE_W-1:0] rx_sr;
    logic [3:0]            edge_cnt;
    logic                  tick;
    logic                  rx_bit;
    spi_clk_div #(.CLK_DIV(CLK_DIV)) u_div (
        .clk  (clk),
        .reset(reset),
        .en   (state != IDLE),
        .tick (tick)
    );
`ifdef SPI_MASTER_LOOPBACK_EN
    logic unused_miso;
    assign unused_miso = spi_miso;
    assign rx_bit = spi_mosi;
`else
    logic [1:0] miso_sync;
    always_ff @(posedge clk or posedge reset)
        if (reset) miso_sync <= '0;
        else miso_sync <= {miso_sync[0], spi_miso};
    assign rx_bit = miso_sync[1];
`endif
    // edge_cnt counts SCLK edges within SHIFT; edge 15 is the 8th falling edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            tx_sr    <= '0;
            rx_sr    <= '0;
            edge_cnt <= '0;
            tx_ready <= 1'b0;
            busy     <= 1'b0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            spi_sclk <= 1'b0;
            spi_mosi <= 1'b0;
            spi_cs_n <= 1'b1;
        end else begin
            rx_valid <= 1'b0;
            case (state)
                IDLE: if (tx_valid && tx_ready) begin
                    state    <= SETUP;
                    tx_sr    <= tx_data[SPI_BYTE_W-2:0];
                    spi_mosi <= tx_data[SPI_BYTE_W-1];
                    spi_cs_n <= 1'b0;
                    tx_ready <= 1'b0;
                    busy     <= 1'b1;
                    edge_cnt <= '0;
                end else tx_ready <= 1'b1;
                SETUP: if (tick) state <= SHIFT;
                SHIFT: if (tick) begin
                    spi_sclk <= !spi_sclk;
                    edge_cnt <= edge_cnt + 1'b1;
                    if (!spi_sclk) rx_sr <= {rx_sr[SPI_BYTE_W-2:0], rx_bit};
                    else if (edge_cnt != 4'd15) begin
                        spi_mosi <= tx_sr[SPI_BYTE_W-2];
                        tx_sr    <= tx_sr << 1;
                    end
                    if (edge_cnt == 4'd15) state <= HOLD;
                end
                HOLD: if (tick) begin
                    state    <= GAP;
                    spi_cs_n <= 1'b1;
                    spi_mosi <= 1'b0;
                    rx_data  <= rx_sr;
                    rx_valid <= 1'b1;
                end
                GAP: if (tick) begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    tx_ready <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: directed bytes with a mode-0 slave model; a monitor pops the scoreboard on each rx_valid.
`timescale 1ns/1ps
module tb_spi_master;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       spi_miso = 1'b0;
    logic       tx_ready, rx_valid, busy, spi_sclk, spi_mosi, spi_cs_n;
    logic [7:0] rx_data;
`ifdef SPI_MASTER_LOOPBACK_EN
    localparam bit LB = 1'b1;
`else
    localparam bit LB = 1'b0;
`endif
    always #5 clk = ~clk;
    spi_master #(.CLK_DIV(4)) dut (
        .clk     (clk),
        .reset   (reset),
        .tx_data (tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .rx_data (rx_data),
        .rx_valid(rx_valid),
        .busy    (busy),
        .spi_sclk(spi_sclk),
        .spi_mosi(spi_mosi),
        .spi_cs_n(spi_cs_n),
        .spi_miso(spi_miso)
    );
    typedef struct {
        logic [7:0] rx;
        logic [7:0] mosi;
    } exp_t;
    exp_t exp_q[$];
    exp_t e;
    int n_pass = 0, n_tot = 0, m_pass = 0, m_tot = 0;
    int m_rx_cnt = 0, m_rx_cyc = 0, mosi_bad = 0;
    int lo_cnt = 0, hi_cnt = 0, last_low = 0, last_high = 0;
    int rises = 0, cs_falls = 0;
    logic rx_q = 1'b0, cs_q = 1'b1, sclk_q = 1'b0;
    logic sclk_at_fall = 1'b1, sclk_at_rise = 1'b1;
    logic [7:0] slave_byte = 8'h00, s_sr = 8'h00, mosi_cap = 8'h00;
    time last_rise_t = 0, sclk_period = 0;

    // Mode-0 slave: presents bit 7 at CS fall, shifts on each SCLK fall, captures MOSI on each rise
    always @(spi_cs_n or spi_sclk) begin
        if (cs_q && !spi_cs_n) begin
            s_sr = slave_byte;
            spi_miso = s_sr[7];
            mosi_cap = 8'h00;
            rises = 0;
            cs_falls++;
            sclk_at_fall = spi_sclk;
        end
        if (!cs_q && spi_cs_n) sclk_at_rise = spi_sclk;
        if (!sclk_q && spi_sclk) begin
            mosi_cap = {mosi_cap[6:0], spi_mosi};
            if (rises > 0) sclk_period = $time - last_rise_t;
            last_rise_t = $time;
            rises++;
        end
        if (sclk_q && !spi_sclk && !spi_cs_n) begin
            s_sr = s_sr << 1;
            spi_miso = s_sr[7];
        end
        cs_q = spi_cs_n;
        sclk_q = spi_sclk;
    end

    always @(negedge clk) begin
        if (spi_cs_n) begin
            if (lo_cnt > 0) last_low = lo_cnt;
            lo_cnt = 0;
            hi_cnt++;
        end else begin
            if (hi_cnt > 0) last_high = hi_cnt;
            hi_cnt = 0;
            lo_cnt++;
        end
        if (spi_cs_n && spi_mosi) mosi_bad++;
        if (rx_valid) begin
            m_rx_cyc++;
            if (!rx_q) begin
                m_rx_cnt++;
                m_tot++;
                if (exp_q.size() == 0)
                    $display("FAIL rx_unexpected: got rx_data=%h with nothing expected", rx_data);
                else begin
                    e = exp_q.pop_front();
                    if (rx_data === e.rx && mosi_cap === e.mosi) m_pass++;
                    else $display("FAIL rx_byte: got rx_data=%h mosi=%h, expected rx_data=%h mosi=%h",
                                  rx_data, mosi_cap, e.rx, e.mosi);
                end
            end
        end
        rx_q = rx_valid;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic send(input logic [7:0] d, input logic [7:0] sb, input bit push, input bit keep);
        int k = 0;
        exp_t x;
        @(negedge clk);
        slave_byte = sb;
        if (push) begin
            x.mosi = d;
            x.rx = LB ? d : sb;
            exp_q.push_back(x);
        end
        tx_data = d;
        tx_valid = 1'b1;
        while (!tx_ready && k < 400) begin
            @(negedge clk);
            k++;
        end
        @(posedge clk);
        #1;
        if (!keep) tx_valid = 1'b0;
        chk("accept_wait", 32'(k < 400), 1);
    endtask

    task automatic wait_rx(input int n);
        int k = 0;
        while ((m_rx_cnt < n || !tx_ready) && k < 3000) begin
            @(negedge clk);
            k++;
        end
        chk("rx_wait", 32'(m_rx_cnt >= n && tx_ready), 1);
    endtask

    task automatic wait_rises(input int n);
        int k = 0;
        while (rises < n && k < 500) begin
            @(negedge clk);
            k++;
        end
        chk("rise_wait", 32'(rises >= n), 1);
    endtask

    initial begin
        int c0;
        repeat (3) @(negedge clk);
        chk("rst_tx_ready", 32'(tx_ready), 0);
        chk("rst_cs_n", 32'(spi_cs_n), 1);
        chk("rst_sclk", 32'(spi_sclk), 0);
        chk("rst_mosi", 32'(spi_mosi), 0);
        chk("rst_rx_valid", 32'(rx_valid), 0);
        chk("rst_rx_data", 32'(rx_data), 0);
        chk("rst_busy", 32'(busy), 0);
        reset = 1'b0;
        #1 chk("tx_ready_before_edge", 32'(tx_ready), 0);
        @(posedge clk);
        #1 chk("tx_ready_first_edge", 32'(tx_ready), 1);

        send(8'hA5, 8'h3C, 1'b1, 1'b0);
        chk("start_cs_n", 32'(spi_cs_n), 0);
        chk("start_mosi_msb", 32'(spi_mosi), 1);
        chk("start_busy", 32'(busy), 1);
        chk("start_tx_ready", 32'(tx_ready), 0);
        wait_rx(1);
        chk("cs_low_clks", 32'(last_low), 72);
        chk("sclk_period_ns", 32'(sclk_period), 80);
        chk("sclk_at_cs_fall", 32'(sclk_at_fall), 0);
        chk("sclk_at_cs_rise", 32'(sclk_at_rise), 0);

        send(8'h01, 8'hC3, 1'b1, 1'b1);
        send(8'h80, 8'h5A, 1'b1, 1'b0);
        wait_rx(3);
        chk("b2b_cs_gap_ge4", 32'(last_high >= 4), 1);
        chk("b2b_rx_count", 32'(m_rx_cnt), 3);

        send(8'h5A, 8'hE7, 1'b1, 1'b0);
        wait_rx(4);

        send(8'h96, 8'h69, 1'b0, 1'b0);
        wait_rises(3);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("abort_cs_n", 32'(spi_cs_n), 1);
        chk("abort_sclk", 32'(spi_sclk), 0);
        chk("abort_mosi", 32'(spi_mosi), 0);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_tx_ready", 32'(tx_ready), 0);
        chk("abort_rx_data", 32'(rx_data), 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (100) @(negedge clk);
        chk("abort_no_rx_valid", 32'(m_rx_cnt), 4);
        send(8'hFF, 8'h81, 1'b1, 1'b0);
        wait_rx(5);

        c0 = cs_falls;
        send(8'h12, 8'h34, 1'b1, 1'b0);
        wait_rises(2);
        @(negedge clk);
        tx_data = 8'h77;
        tx_valid = 1'b1;
        #1 chk("busy_tx_ready", 32'(tx_ready), 0);
        @(negedge clk);
        tx_valid = 1'b0;
        wait_rx(6);
        repeat (20) @(negedge clk);
        chk("busy_byte_count", 32'(cs_falls), 32'(c0 + 1));
        chk("final_busy", 32'(busy), 0);

        chk("mosi_while_cs_high", 32'(mosi_bad), 0);
        chk("rx_valid_width", 32'(m_rx_cyc), 32'(m_rx_cnt));
        chk("scoreboard_empty", 32'(exp_q.size()), 0);
        $display("%0d/%0d checks passed", n_pass + m_pass, n_tot + m_tot);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end
endmodule
